sprite_compositor: RTL and testbench

Parametrised per-pixel compositor that replaces the fixed ball/bullet/box colour mapper with N_OBJ generic objects. Each object carries position, size, shape, colour and an active flag. All are written through a handshaked register port into a shadow bank, which is committed to the live bank at frame start, so objects never tear mid-frame. The block sits between the VGA controller (DrawX/DrawY/blank) and the video DAC outputs. It also reports per-frame overlap between object 0 (player) and every other object for game logic.

---
 rtl/sprite_pkg.sv | 27 ++
 rtl/obj_hit_test.sv | 63 ++++++
 rtl/sprite_compositor.sv | 180 ++++++++++++++++++
 tb/tb_sprite_compositor.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared types and defaults for the sprite compositor.
// obj_t is sized from the default COORD_W/COLOR_W below; the top-level
// parameters must match these widths.
package sprite_pkg;

    localparam int N_OBJ_DEF   = 8;
    localparam int COORD_W_DEF = 10;
    localparam int COLOR_W_DEF = 8;

    // Blue ramp base for the background gradient
    localparam logic [7:0] BG_BASE = 8'h7f;

    typedef enum logic {
        SHAPE_BOX    = 1'b0,
        SHAPE_CIRCLE = 1'b1
    } shape_e;

    typedef struct packed {
        logic [COORD_W_DEF-1:0]   x;
        logic [COORD_W_DEF-1:0]   y;
        logic [COORD_W_DEF-1:0]   size;
        shape_e                   shape;
        logic [3*COLOR_W_DEF-1:0] color;
        logic                     act;
    } obj_t;

endpackage

// File: rtl/obj_hit_test.sv
// Combinational coverage test of one object against the current pixel.
// Macro SPRITE_CIRCLE_EN builds the circle path; without it every object
// is tested as a box and the shape bit is ignored.
module obj_hit_test
    import sprite_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  obj_t               obj,
    input  logic [COORD_W-1:0] DrawX,
    input  logic [COORD_W-1:0] DrawY,
    output logic               hit
);

    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             box_hit;
    logic             shape_hit;

    // Box test; ends carry one extra bit so edge-touching boxes never wrap
    always_comb begin
        x_end   = {1'b0, obj.x} + {1'b0, obj.size};
        y_end   = {1'b0, obj.y} + {1'b0, obj.size};
        box_hit = (DrawX >= obj.x) && ({1'b0, DrawX} < x_end) &&
                  (DrawY >= obj.y) && ({1'b0, DrawY} < y_end);
    end

`ifdef SPRITE_CIRCLE_EN
    localparam int DW = COORD_W + 2;
    localparam int SW = 2 * COORD_W + 5;

    logic signed [DW-1:0] dx;
    logic signed [DW-1:0] dy;
    logic signed [SW-1:0] dx_w;
    logic signed [SW-1:0] dy_w;
    logic signed [SW-1:0] rs_w;
    logic signed [SW-1:0] d2;
    logic signed [SW-1:0] r2;
    logic                 unused_color;

    // Circle test around (x, y); size is the radius
    always_comb begin
        dx        = $signed({2'b00, DrawX}) - $signed({2'b00, obj.x});
        dy        = $signed({2'b00, DrawY}) - $signed({2'b00, obj.y});
        dx_w      = SW'(dx);
        dy_w      = SW'(dy);
        rs_w      = $signed(SW'({1'b0, obj.size}));
        d2        = dx_w * dx_w + dy_w * dy_w;
        r2        = rs_w * rs_w;
        shape_hit = (obj.shape == SHAPE_CIRCLE) ? (d2 <= r2) : box_hit;
    end

    assign unused_color = ^obj.color;
`else
    logic unused_fields;

    assign shape_hit     = box_hit;
    assign unused_fields = ^{obj.shape, obj.color};
`endif

    assign hit = obj.act && shape_hit;

endmodule

// File: rtl/sprite_compositor.sv
// Per-pixel compositor for N_OBJ objects with shadow/live banks, a 2-stage
// pixel pipeline, priority select and per-frame player collision flags.
// Macro SPRITE_CIRCLE_EN (see obj_hit_test) enables circle shapes.
module sprite_compositor
    import sprite_pkg::*;
#(
    parameter int N_OBJ   = N_OBJ_DEF,
    parameter int COORD_W = COORD_W_DEF,
    parameter int COLOR_W = COLOR_W_DEF
) (
    input  logic                     pixel_clk,
    input  logic                     reset_n,
    input  logic [COORD_W-1:0]       DrawX,
    input  logic [COORD_W-1:0]       DrawY,
    input  logic                     blank,
    input  logic                     frame_start,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [$clog2(N_OBJ)-1:0] wr_idx,
    input  logic [COORD_W-1:0]       wr_x,
    input  logic [COORD_W-1:0]       wr_y,
    input  logic [COORD_W-1:0]       wr_size,
    input  logic                     wr_shape,
    input  logic [3*COLOR_W-1:0]     wr_color,
    input  logic                     wr_act,
    output logic [COLOR_W-1:0]       Red,
    output logic [COLOR_W-1:0]       Green,
    output logic [COLOR_W-1:0]       Blue,
    output logic                     hit_valid,
    output logic [$clog2(N_OBJ)-1:0] hit_idx,
    output logic [N_OBJ-1:0]         collide
);

    localparam int IDX_W = $clog2(N_OBJ);

    obj_t shadow_q [N_OBJ];
    obj_t shadow_d [N_OBJ];
    obj_t live_q   [N_OBJ];
    obj_t live_d   [N_OBJ];

    logic [N_OBJ-1:0] hit_vec;

    // Stage 1 state
    logic [N_OBJ-1:0] hit_s1_q, hit_s1_d;
    logic             blank_s1_q, blank_s1_d;
    logic [6:0]       bgx_s1_q, bgx_s1_d;

    // Stage 2 (output) state
    logic [COLOR_W-1:0] red_q, red_d;
    logic [COLOR_W-1:0] green_q, green_d;
    logic [COLOR_W-1:0] blue_q, blue_d;
    logic               hit_valid_q, hit_valid_d;
    logic [IDX_W-1:0]   hit_idx_q, hit_idx_d;

    logic [N_OBJ-1:0] acc_q, acc_d;
    logic [N_OBJ-1:0] collide_q, collide_d;

    logic             win_valid;
    logic [IDX_W-1:0] win_idx;
    logic [7:0]       bg8;

    // Writes are held off during commit so shadow and live never race
    assign wr_ready = !frame_start;

    // Shadow write port (out-of-range indices match no slot) and frame commit
    always_comb begin
        for (int i = 0; i < N_OBJ; i++) begin
            shadow_d[i] = shadow_q[i];
            if (wr_valid && wr_ready && (wr_idx == IDX_W'(i))) begin
                shadow_d[i] = '{x: wr_x, y: wr_y, size: wr_size,
                                shape: shape_e'(wr_shape), color: wr_color,
                                act: wr_act};
            end
            live_d[i] = frame_start ? shadow_q[i] : live_q[i];
        end
    end

    genvar g;
    generate
        for (g = 0; g < N_OBJ; g++) begin : g_obj
            obj_hit_test #(.COORD_W(COORD_W)) u_hit (
                .obj   (live_q[g]),
                .DrawX (DrawX),
                .DrawY (DrawY),
                .hit   (hit_vec[g])
            );
        end
    endgenerate

    // Stage 1: capture hit vector, blank and the background ramp bits
    always_comb begin
        hit_s1_d   = blank ? hit_vec : '0;
        blank_s1_d = blank;
        bgx_s1_d   = DrawX[COORD_W-1 -: 7];
    end

    // Stage 2: lowest index wins; colour or background ramp, black in blanking
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int i = N_OBJ - 1; i >= 0; i--) begin
            if (hit_s1_q[i]) begin
                win_valid = 1'b1;
                win_idx   = IDX_W'(i);
            end
        end
        bg8         = BG_BASE - {1'b0, bgx_s1_q};
        red_d       = '0;
        green_d     = '0;
        blue_d      = '0;
        hit_valid_d = 1'b0;
        hit_idx_d   = '0;
        if (blank_s1_q) begin
            if (win_valid) begin
                red_d       = live_q[win_idx].color[3*COLOR_W-1 -: COLOR_W];
                green_d     = live_q[win_idx].color[2*COLOR_W-1 -: COLOR_W];
                blue_d      = live_q[win_idx].color[COLOR_W-1:0];
                hit_valid_d = 1'b1;
                hit_idx_d   = win_idx;
            end else begin
                blue_d = COLOR_W'(bg8);
            end
        end
    end

    // Player overlap accumulator; the frame_start pixel is not accumulated
    always_comb begin
        acc_d     = acc_q;
        collide_d = collide_q;
        if (frame_start) begin
            collide_d = acc_q;
            acc_d     = '0;
        end else if (blank && hit_vec[0]) begin
            acc_d = acc_q | (hit_vec & ~N_OBJ'(1));
        end
    end

    // All state registers
    always_ff @(posedge pixel_clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_q[i] <= '0;
                live_q[i]   <= '0;
            end
            hit_s1_q    <= '0;
            blank_s1_q  <= 1'b0;
            bgx_s1_q    <= '0;
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            hit_valid_q <= 1'b0;
            hit_idx_q   <= '0;
            acc_q       <= '0;
            collide_q   <= '0;
        end else begin
            for (int i = 0; i < N_OBJ; i++) begin
                shadow_q[i] <= shadow_d[i];
                live_q[i]   <= live_d[i];
            end
            hit_s1_q    <= hit_s1_d;
            blank_s1_q  <= blank_s1_d;
            bgx_s1_q    <= bgx_s1_d;
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            hit_valid_q <= hit_valid_d;
            hit_idx_q   <= hit_idx_d;
            acc_q       <= acc_d;
            collide_q   <= collide_d;
        end
    end

    assign Red       = red_q;
    assign Green     = green_q;
    assign Blue      = blue_q;
    assign hit_valid = hit_valid_q;
    assign hit_idx   = hit_idx_q;
    assign collide   = collide_q;

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: pixel expectations are queued when
// driven and compared when they leave the 2-cycle pipeline.
module tb_sprite_compositor;

    logic        pixel_clk;
    logic        reset_n;
    logic [9:0]  DrawX, DrawY;
    logic        blank, frame_start;
    logic        wr_valid;
    logic        wr_ready;
    logic [2:0]  wr_idx;
    logic [9:0]  wr_x, wr_y, wr_size;
    logic        wr_shape;
    logic [23:0] wr_color;
    logic        wr_act;
    logic [7:0]  Red, Green, Blue;
    logic        hit_valid;
    logic [2:0]  hit_idx;
    logic [7:0]  collide;

    sprite_compositor dut (
        .pixel_clk(pixel_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .blank(blank), .frame_start(frame_start), .wr_valid(wr_valid),
        .wr_ready(wr_ready), .wr_idx(wr_idx), .wr_x(wr_x), .wr_y(wr_y),
        .wr_size(wr_size), .wr_shape(wr_shape), .wr_color(wr_color),
        .wr_act(wr_act), .Red(Red), .Green(Green), .Blue(Blue),
        .hit_valid(hit_valid), .hit_idx(hit_idx), .collide(collide)
    );

    initial begin
        pixel_clk = 1'b0;
        forever #5 pixel_clk = ~pixel_clk;
    end

    typedef struct {
        int          due;
        logic [27:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  cyc     = 0;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: compares the scoreboard head when its cycle comes due
    always @(posedge pixel_clk) begin
        cyc = cyc + 1;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            sb_t e;
            e = sb.pop_front();
            chk(e.tag, {36'h0, Red, Green, Blue, hit_valid, hit_idx}, {36'h0, e.exp});
        end
    end

    function automatic logic [23:0] bg(input int x);
        logic [9:0] xv;
        xv = 10'(x);
        return {16'h0, 8'h7f - {1'b0, xv[9:3]}};
    endfunction

    task automatic push_exp(input string tag, input logic [23:0] rgb, input logic hv, input int idx);
        sb.push_back('{due: cyc + 2, exp: {rgb, hv, 3'(idx)}, tag: tag});
    endtask

    task automatic pix(input string tag, input int x, input int y,
                       input logic [23:0] rgb, input logic hv, input int idx);
        @(negedge pixel_clk);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = 1'b1;
        push_exp(tag, rgb, hv, idx);
    endtask

    task automatic pix_bg(input string tag, input int x, input int y);
        pix(tag, x, y, bg(x), 1'b0, 0);
    endtask

    task automatic wr(input int idx, input int x, input int y, input int sz,
                      input logic shape, input logic [23:0] col, input logic act);
        @(negedge pixel_clk);
        blank    = 1'b0;
        wr_valid = 1'b1;
        wr_idx   = 3'(idx);
        wr_x     = 10'(x);
        wr_y     = 10'(y);
        wr_size  = 10'(sz);
        wr_shape = shape;
        wr_color = col;
        wr_act   = act;
        #1 chk("wr_ready_idle", {63'h0, wr_ready}, 64'h1);
        @(posedge pixel_clk);
        #1 wr_valid = 1'b0;
    endtask

    task automatic commit();
        @(negedge pixel_clk);
        blank       = 1'b0;
        frame_start = 1'b1;
        @(negedge pixel_clk);
        frame_start = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge pixel_clk);
        @(negedge pixel_clk);
        blank = 1'b0;
        chk("sb_drain", 64'(sb.size()), 64'h0);
    endtask

    initial begin
        reset_n = 1'b0; DrawX = 10'd80; DrawY = 10'd0; blank = 1'b1;
        frame_start = 1'b0; wr_valid = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0;
        wr_size = '0; wr_shape = 1'b0; wr_color = '0; wr_act = 1'b0;

        // Reset state
        repeat (3) @(negedge pixel_clk);
        chk("reset_out", {36'h0, Red, Green, Blue, hit_valid, hit_idx}, 64'h0);
        chk("reset_collide", {56'h0, collide}, 64'h0);
        chk("reset_wr_ready", {63'h0, wr_ready}, 64'h1);

        // Background ramp
        reset_n = 1'b1;
        pix("bg_x80", 80, 0, 24'h000075, 1'b0, 0);
        drain();

        // Commit timing: write is invisible until the next frame_start
        wr(3, 100, 100, 20, 1'b0, 24'hff0000, 1'b1);
        pix_bg("obj3_precommit", 105, 105);
        drain();
        commit();
        pix("obj3_hit", 105, 105, 24'hff0000, 1'b1, 3);
        pix("obj3_last_col", 119, 105, 24'hff0000, 1'b1, 3);
        pix_bg("obj3_right_edge", 120, 105);
        drain();

        // Priority
        wr(1, 40, 40, 20, 1'b0, 24'h00ff00, 1'b1);
        wr(5, 45, 45, 20, 1'b0, 24'h0000ff, 1'b1);
        commit();
        pix("prio_obj1", 50, 50, 24'h00ff00, 1'b1, 1);
        pix("prio_obj5_only", 62, 62, 24'h0000ff, 1'b1, 5);
        drain();
        wr(1, 40, 40, 20, 1'b0, 24'h00ff00, 1'b0);
        commit();
        pix("prio_obj1_off", 50, 50, 24'h0000ff, 1'b1, 5);
        drain();

        // Circle object (drawn as a box when circles are not built)
        wr(6, 200, 200, 10, 1'b1, 24'h123456, 1'b1);
        commit();
`ifdef SPRITE_CIRCLE_EN
        pix("circ_rim", 210, 200, 24'h123456, 1'b1, 6);
        pix_bg("circ_out", 208, 207);
`else
        pix_bg("circ_as_box_miss", 191, 191);
        pix("circ_as_box_hit", 205, 205, 24'h123456, 1'b1, 6);
`endif
        drain();

        // Right edge: no wrap to DrawX 0..6
        wr(7, 1015, 0, 16, 1'b0, 24'habcdef, 1'b1);
        commit();
        pix_bg("edge_left_miss", 1014, 5);
        pix("edge_first", 1015, 5, 24'habcdef, 1'b1, 7);
        pix("edge_last", 1023, 5, 24'habcdef, 1'b1, 7);
        pix_bg("edge_nowrap0", 0, 5);
        pix_bg("edge_nowrap6", 6, 5);
        drain();

        // Collision between player and obj2
        wr(0, 300, 300, 1, 1'b0, 24'hffffff, 1'b1);
        wr(2, 300, 300, 1, 1'b0, 24'h111111, 1'b1);
        commit();
        chk("collide_before", {56'h0, collide}, 64'h0);
        pix("coll_pixel", 300, 300, 24'hffffff, 1'b1, 0);
        pix_bg("coll_neighbor", 301, 300);
        drain();
        commit();
        chk("collide_set", {56'h0, collide}, 64'h04);
        commit();
        chk("collide_clear", {56'h0, collide}, 64'h0);

        // Write during frame_start is refused
        @(negedge pixel_clk);
        blank = 1'b0; frame_start = 1'b1; wr_valid = 1'b1;
        wr_idx = 3'd4; wr_x = 10'd400; wr_y = 10'd400; wr_size = 10'd10;
        wr_shape = 1'b0; wr_color = 24'h00ff00; wr_act = 1'b1;
        #1 chk("wr_ready_fs", {63'h0, wr_ready}, 64'h0);
        @(negedge pixel_clk);
        frame_start = 1'b0; wr_valid = 1'b0;
        commit();
        pix_bg("fs_write_dropped", 405, 405);
        drain();

        // Mid-frame reset clears outputs and banks
        pix("pre_reset", 105, 105, 24'hff0000, 1'b1, 3);
        drain();
        @(negedge pixel_clk);
        DrawX = 10'd105; DrawY = 10'd105; blank = 1'b1;
        repeat (2) @(negedge pixel_clk);
        chk("live_red", {56'h0, Red}, 64'hff);
        #2 reset_n = 1'b0;
        #1 chk("reset_mid_out", {36'h0, Red, Green, Blue, hit_valid, hit_idx}, 64'h0);
        @(negedge pixel_clk);
        reset_n = 1'b1;
        push_exp("post_reset_bg", bg(105), 1'b0, 0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
